// File: rtl/sbqm_pkg.sv
// Shared types and constants for the SBqM queue monitor.
package sbqm_pkg;

  // Wait-time divider sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Photocell event code, packed as {exit, enter}.
  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_ENTER = 2'b01;
  localparam logic [1:0] EV_EXIT  = 2'b10;
  localparam logic [1:0] EV_BOTH  = 2'b11;

  // Time units spent per customer at a teller.
  localparam int SERVICE_T_DEFAULT = 3;

endpackage

// File: rtl/sbqm_queue_monitor_if.sv
// Sensor, control and status bundle between the photocell pads, the queue
// monitor and the SBqM display/controller logic.
interface sbqm_queue_monitor_if #(
  parameter int N      = 3,
  parameter int TW     = 2,
  parameter int WAIT_W = 8
);
  logic              front_photocell;
  logic              back_photocell;
  logic [TW-1:0]     tellers;
  logic              err_clr;
  logic [N-1:0]      pcount;
  logic              full;
  logic              empty;
  logic [WAIT_W-1:0] wait_time;
  logic              wait_valid;
  logic              busy;
  logic              full_err;
  logic              empty_err;

  // Pads/controller side: drives sensors and controls, observes status.
  modport master (
    output front_photocell, back_photocell, tellers, err_clr,
    input  pcount, full, empty, wait_time, wait_valid, busy, full_err, empty_err
  );

  // Queue monitor side.
  modport slave (
    input  front_photocell, back_photocell, tellers, err_clr,
    output pcount, full, empty, wait_time, wait_valid, busy, full_err, empty_err
  );
endinterface

// File: rtl/photocell_filter.sv
// Photocell conditioning: 2-FF synchronizer, debounce, rising-edge pulse.
module photocell_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pad level into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/sbqm_queue_monitor.sv
// SBqM queue monitor: filtered photocell events drive a saturating queue
// count; a restoring divider turns count and teller number into a wait time.
module sbqm_queue_monitor
  import sbqm_pkg::*;
#(
  parameter int N         = 3,
  parameter int DEBOUNCE  = 4,
  parameter int SERVICE_T = SERVICE_T_DEFAULT,
  parameter int TW        = 2,
  parameter int WAIT_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sbqm_queue_monitor_if.slave  bus
);
  localparam int BW = $clog2(WAIT_W + 1);

  logic              front_level, back_level, front_rise, back_rise;
  logic              unused_levels;
  logic [1:0]        ev;
  logic [N-1:0]      pcount, pcount_nxt;
  logic              full_set, empty_set, full_err, empty_err;
  logic [TW-1:0]     tellers_q, op_tellers, den, t_eff;
  logic [N-1:0]      op_pcount;
  logic [WAIT_W-1:0] num, num_load, wait_time;
  logic [TW:0]       rem, rem_sh;
  logic [BW-1:0]     bit_cnt;
  logic              q_bit, request;
  div_state_t        state, state_nxt;

  photocell_filter #(.DEBOUNCE(DEBOUNCE)) u_front (
    .clk(clk), .rst_n(rst_n), .raw(bus.front_photocell),
    .level(front_level), .rise(front_rise)
  );

  photocell_filter #(.DEBOUNCE(DEBOUNCE)) u_back (
    .clk(clk), .rst_n(rst_n), .raw(bus.back_photocell),
    .level(back_level), .rise(back_rise)
  );

  // Only the edge pulses matter here; the filtered levels are left unused.
  assign unused_levels = front_level ^ back_level;
  assign ev = {back_rise, front_rise};

  // Next queue count and saturation error requests from this cycle's events.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    pcount_nxt = pcount;
    full_set   = 1'b0;
    empty_set  = 1'b0;
    case (ev)
      EV_ENTER: if (pcount == '1) full_set  = 1'b1; else pcount_nxt = pcount + 1'b1;
      EV_EXIT:  if (pcount == '0) empty_set = 1'b1; else pcount_nxt = pcount - 1'b1;
      default:  pcount_nxt = pcount;
    endcase
  end

  // Queue count, sticky errors (set beats clear), registered teller count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount    <= '0;
      full_err  <= 1'b0;
      empty_err <= 1'b0;
      tellers_q <= '0;
    end else begin
      pcount    <= pcount_nxt;
      full_err  <= full_set  | (full_err  & ~bus.err_clr);
      empty_err <= empty_set | (empty_err & ~bus.err_clr);
      tellers_q <= bus.tellers;
    end
  end

  // Divider operands and one restoring-division step.
  always_comb begin
    request = (pcount != op_pcount) || (tellers_q != op_tellers);
    t_eff   = (tellers_q == '0) ? TW'(1) : tellers_q;
    if (pcount == '0) num_load = '0;
    else num_load = WAIT_W'(SERVICE_T * (int'(pcount) + int'(t_eff) - 1));
    rem_sh = {rem[TW-1:0], num[WAIT_W-1]};
    q_bit  = (rem_sh >= {1'b0, den});
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Divider sequencing; a stale result in DONE restarts on the latest operands.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (request) state_nxt = LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (bit_cnt == BW'(WAIT_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = request ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider datapath: latch operands, shift quotient into num, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_pcount  <= '0;
      op_tellers <= '0;
      den        <= '0;
      num        <= '0;
      rem        <= '0;
      bit_cnt    <= '0;
      wait_time  <= '0;
    end else begin
      case (state)
        LOAD: begin
          op_pcount  <= pcount;
          op_tellers <= tellers_q;
          den        <= t_eff;
          num        <= num_load;
          rem        <= '0;
          bit_cnt    <= '0;
        end
        DIV: begin
          rem     <= q_bit ? (rem_sh - {1'b0, den}) : rem_sh;
          num     <= {num[WAIT_W-2:0], q_bit};
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE:    if (!request) wait_time <= num;
        default: ;
      endcase
    end
  end

  assign bus.pcount     = pcount;
  assign bus.full       = (pcount == '1);
  assign bus.empty      = (pcount == '0);
  assign bus.wait_time  = wait_time;
  assign bus.wait_valid = (state == IDLE) && !request;
  assign bus.busy       = (state != IDLE);
  assign bus.full_err   = full_err;
  assign bus.empty_err  = empty_err;

endmodule

// File: tb/tb_sbqm_queue_monitor.sv
// Directed bench for sbqm_queue_monitor with default parameters
// (N=3, DEBOUNCE=4, SERVICE_T=3, TW=2, WAIT_W=8).
module tb_sbqm_queue_monitor;
  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  sbqm_queue_monitor_if #(.N(3), .TW(2), .WAIT_W(8)) bus ();

  sbqm_queue_monitor #(
    .N(3), .DEBOUNCE(4), .SERVICE_T(3), .TW(2), .WAIT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] t);
    rst_n = 1'b0;
    bus.front_photocell = 1'b0;
    bus.back_photocell  = 1'b0;
    bus.err_clr = 1'b0;
    bus.tellers = t;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Hold the chosen sensors high long enough for one event, then low to re-arm.
  task automatic pulse_sensor(input logic f, input logic b);
    bus.front_photocell = f;
    bus.back_photocell  = b;
    tick(7);
    bus.front_photocell = 1'b0;
    bus.back_photocell  = 1'b0;
    tick(7);
  endtask

  // Wait (bounded) until the estimate is valid and the divider idle.
  task automatic settle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.wait_valid && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok) $display("FAIL %s_settle: wait_valid=%0b busy=%0b after 100 cycles, need 1/0",
                      name, bus.wait_valid, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.front_photocell = 1'b1;
    bus.back_photocell  = 1'b0;
    bus.err_clr = 1'b0;
    bus.tellers = 2'd0;
    tick(3);
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL rst_pcount: got %0d need 0", bus.pcount); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %0b need 1", bus.empty); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %0b need 0", bus.full); else n_pass++;
    n_total++; if (bus.wait_time !== 8'd0) $display("FAIL rst_wait_time: got %0d need 0", bus.wait_time); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b1) $display("FAIL rst_wait_valid: got %0b need 1", bus.wait_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b need 0", bus.busy); else n_pass++;
    n_total++; if ({bus.full_err, bus.empty_err} !== 2'b00) $display("FAIL rst_errs: got %b need 00", {bus.full_err, bus.empty_err}); else n_pass++;
    rst_n = 1'b1;
    tick(6);
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL rst_no_early_count: got %0d need 0", bus.pcount); else n_pass++;
    tick(1);
    n_total++; if (bus.pcount !== 3'd1) $display("FAIL rst_count_after_debounce: got %0d need 1", bus.pcount); else n_pass++;
    bus.front_photocell = 1'b0;
  endtask

  task automatic test_single_entry;
    do_reset(2'd1);
    settle("single_pre");
    bus.front_photocell = 1'b1;
    tick(6);
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL single_edge6_pcount: got %0d need 0", bus.pcount); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b1) $display("FAIL single_edge6_valid: got %0b need 1", bus.wait_valid); else n_pass++;
    tick(1);
    n_total++; if (bus.pcount !== 3'd1) $display("FAIL single_edge7_pcount: got %0d need 1", bus.pcount); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b0) $display("FAIL single_edge7_valid: got %0b need 0", bus.wait_valid); else n_pass++;
    tick(3);
    bus.front_photocell = 1'b0;
    tick(7);
    n_total++; if (bus.wait_valid !== 1'b0) $display("FAIL single_pre_done_valid: got %0b need 0", bus.wait_valid); else n_pass++;
    n_total++; if (bus.wait_time !== 8'd0) $display("FAIL single_pre_done_time: got %0d need 0", bus.wait_time); else n_pass++;
    tick(1);
    n_total++; if (bus.wait_time !== 8'd3) $display("FAIL single_wait_time: got %0d need 3", bus.wait_time); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b1) $display("FAIL single_wait_valid: got %0b need 1", bus.wait_valid); else n_pass++;
    tick(8);
  endtask

  task automatic test_glitch;
    bit dropped = 1'b0;
    bit moved   = 1'b0;
    do_reset(2'd1);
    settle("glitch_pre");
    bus.front_photocell = 1'b1;
    tick(3);
    bus.front_photocell = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (!bus.wait_valid) dropped = 1'b1;
      if (bus.pcount !== 3'd0) moved = 1'b1;
    end
    n_total++; if (moved) $display("FAIL glitch_pcount: count moved, got %0d need 0", bus.pcount); else n_pass++;
    n_total++; if (dropped) $display("FAIL glitch_valid: wait_valid dropped, need steady 1"); else n_pass++;
  endtask

  task automatic test_saturation;
    do_reset(2'd1);
    settle("sat_pre");
    for (int i = 0; i < 7; i++) pulse_sensor(1'b1, 1'b0);
    n_total++; if (bus.pcount !== 3'd7) $display("FAIL sat_pcount7: got %0d need 7", bus.pcount); else n_pass++;
    n_total++; if (bus.full !== 1'b1) $display("FAIL sat_full: got %0b need 1", bus.full); else n_pass++;
    n_total++; if (bus.full_err !== 1'b0) $display("FAIL sat_full_err_early: got %0b need 0", bus.full_err); else n_pass++;
    pulse_sensor(1'b1, 1'b0);
    n_total++; if (bus.pcount !== 3'd7) $display("FAIL sat_pcount_hold: got %0d need 7", bus.pcount); else n_pass++;
    n_total++; if (bus.full_err !== 1'b1) $display("FAIL sat_full_err: got %0b need 1", bus.full_err); else n_pass++;
    settle("sat_full");
    n_total++; if (bus.wait_time !== 8'd21) $display("FAIL sat_wait_time: got %0d need 21", bus.wait_time); else n_pass++;
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    n_total++; if (bus.full_err !== 1'b0) $display("FAIL sat_err_clr: got %0b need 0", bus.full_err); else n_pass++;
    for (int i = 0; i < 7; i++) pulse_sensor(1'b0, 1'b1);
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL sat_drain: got %0d need 0", bus.pcount); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL sat_empty: got %0b need 1", bus.empty); else n_pass++;
    n_total++; if (bus.empty_err !== 1'b0) $display("FAIL sat_empty_err_early: got %0b need 0", bus.empty_err); else n_pass++;
    pulse_sensor(1'b0, 1'b1);
    n_total++; if (bus.empty_err !== 1'b1) $display("FAIL sat_empty_err: got %0b need 1", bus.empty_err); else n_pass++;
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL sat_pcount_floor: got %0d need 0", bus.pcount); else n_pass++;
  endtask

  task automatic test_simultaneous;
    do_reset(2'd2);
    settle("sim_pre");
    for (int i = 0; i < 5; i++) pulse_sensor(1'b1, 1'b0);
    settle("sim_five");
    n_total++; if (bus.wait_time !== 8'd9) $display("FAIL sim_wait_t2: got %0d need 9", bus.wait_time); else n_pass++;
    pulse_sensor(1'b1, 1'b1);
    n_total++; if (bus.pcount !== 3'd5) $display("FAIL sim_both_hold: got %0d need 5", bus.pcount); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b1) $display("FAIL sim_both_valid: got %0b need 1", bus.wait_valid); else n_pass++;
    bus.tellers = 2'd0;
    settle("sim_t0");
    n_total++; if (bus.wait_time !== 8'd15) $display("FAIL sim_wait_t0: got %0d need 15", bus.wait_time); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int          changes = 0;
    bit          done    = 1'b0;
    logic [7:0]  prev;
    do_reset(2'd1);
    settle("b2b_pre");
    for (int i = 0; i < 3; i++) pulse_sensor(1'b1, 1'b0);
    settle("b2b_three");
    n_total++; if (bus.wait_time !== 8'd9) $display("FAIL b2b_wait_t1: got %0d need 9", bus.wait_time); else n_pass++;
    bus.tellers = 2'd3;
    tick(3);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %0b need 1", bus.busy); else n_pass++;
    bus.tellers = 2'd2;
    prev = bus.wait_time;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (bus.wait_time !== prev) changes++;
      prev = bus.wait_time;
      if (bus.wait_valid && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    n_total++; if (!done) $display("FAIL b2b_settle: no valid result within 80 cycles"); else n_pass++;
    n_total++; if (changes != 1) $display("FAIL b2b_single_update: got %0d updates need 1", changes); else n_pass++;
    n_total++; if (bus.wait_time !== 8'd6) $display("FAIL b2b_final: got %0d need 6", bus.wait_time); else n_pass++;
    bus.tellers = 2'd3;
    tick(4);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: got %0b need 1", bus.busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %0b need 0", bus.busy); else n_pass++;
    n_total++; if (bus.wait_valid !== 1'b1) $display("FAIL abort_valid: got %0b need 1", bus.wait_valid); else n_pass++;
    n_total++; if (bus.wait_time !== 8'd0) $display("FAIL abort_wait_time: got %0d need 0", bus.wait_time); else n_pass++;
    n_total++; if (bus.pcount !== 3'd0) $display("FAIL abort_pcount: got %0d need 0", bus.pcount); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.front_photocell = 1'b0;
    bus.back_photocell  = 1'b0;
    bus.err_clr = 1'b0;
    bus.tellers = 2'd0;
    test_reset;
    test_single_entry;
    test_glitch;
    test_saturation;
    test_simultaneous;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sbqm_queue_monitor.md
Name: sbqm_queue_monitor

Overview:
Parametrised successor to the SBqM people counter. Filters the front/back photocells (2-FF sync, debounce, rising-edge detect) and keeps a saturating queue count with full/empty flags and sticky sensor-error flags. A multi-cycle divider computes the estimated wait time from the queue count and the number of active tellers. Sits between the photocell pads and the SBqM display/controller logic.

Parameters:
N, 3, queue count width; max queue = 2^N-1
DEBOUNCE, 4, consecutive stable cycles required before a filtered photocell level changes (>=1)
SERVICE_T, 3, time units per customer
TW, 2, teller-count input width
WAIT_W, 8, wait-time width; SERVICE_T*(2^N-1 + 2^TW-2) must fit WAIT_W bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
front_photocell  in  1  raw entry sensor, high = beam broken
back_photocell  in  1  raw exit sensor, high = beam broken
tellers  in  TW  number of active tellers
err_clr  in  1  clears both sticky error flags
pcount  out  N  current queue count
full  out  1  pcount == 2^N-1
empty  out  1  pcount == 0
wait_time  out  WAIT_W  last completed wait estimate
wait_valid  out  1  wait_time matches current pcount/tellers
busy  out  1  divider running
full_err  out  1  sticky: entry seen while full
empty_err  out  1  sticky: exit seen while empty

Behaviour:
- Reset (async assert, sync release): pcount 0, empty 1, full 0, wait_time 0, wait_valid 1, busy 0, errors 0; filter levels and debounce counters 0; divider IDLE.
- Filter per photocell: 2-FF synchronizer; counter increments while synced != filtered and clears otherwise; filtered toggles when the counter reaches DEBOUNCE. Event = 1-cycle pulse on filtered rising edge. With raw held stable, pcount updates on the (DEBOUNCE+3)th rising edge after raw is first sampled high. Glitches shorter than DEBOUNCE cycles produce no event.
- Count update, per cycle:
  - enter and exit both set: hold.
  - enter only: +1; if full, hold and set full_err.
  - exit only: -1; if empty, hold and set empty_err.
  - none: hold.
- err_clr clears both error flags. A set in the same cycle wins over the clear.
- Wait estimate: wait = floor(SERVICE_T*(pcount + T - 1) / T), where T = tellers, or 1 if tellers == 0. pcount == 0 gives wait 0.
- Divider FSM: IDLE -> LOAD -> DIV -> DONE -> IDLE.
  - A request is raised when pcount or tellers differs from the last latched operands.
  - LOAD latches the operands and the numerator. DIV is restoring division, one quotient bit per cycle, WAIT_W cycles. DONE writes wait_time.
  - wait_valid drops on the edge where pcount/tellers changes and rises with the wait_time update, WAIT_W+3 edges later. busy is high in LOAD/DIV/DONE.
  - A change during busy sets pending. The current operation finishes without updating wait_time or wait_valid, then restarts on the latest operands, so the latest value wins.
- rst_n asserted mid-division aborts immediately to reset values.

Decomposition:
- Package sbqm_pkg: divider state enum (IDLE, LOAD, DIV, DONE), photocell event-code constants (NONE/ENTER/EXIT/BOTH), default SERVICE_T.
- One sub-module, photocell_filter (params DEBOUNCE; ports clk, rst_n, raw, level, rise). It is instantiated twice. The counter, error flags and divider FSM live in the top.

Test Plan:
- Reset: hold rst_n low 3 cycles with front high -> pcount 0, empty 1, wait_time 0, wait_valid 1, no count after release until debounce completes.
- Single entry: front high 10 cycles, tellers=1 -> pcount 1 at edge 7. wait_valid low that edge, then wait_time 3 / wait_valid 1 at 11 edges after the pcount update (WAIT_W+3).
- Glitch: front high 3 cycles (DEBOUNCE=4) -> pcount unchanged, no wait_valid drop.
- Saturation: 8 debounced entries -> pcount 7, full 1, full_err 1. err_clr pulse -> full_err 0. Exit pulse at empty -> empty_err 1, pcount 0.
- Simultaneous: front and back raise on the same cycle -> pcount unchanged. Arithmetic with pcount=5: tellers=2 -> wait 9; tellers=0 -> wait 15.
- Mid-operation: change tellers while busy -> a single final wait_time for the new operands. Assert rst_n mid-DIV -> busy 0, wait_valid 1, wait_time 0.
